// File: rtl/gauss_stream_filter.sv
// gauss_stream_filter
// Streaming KSIZE x KSIZE binomial (Gaussian) blur for one raster-ordered
// grayscale frame. Pixels arrive on a valid/ready stream. KSIZE-1 line
// buffers and a KSIZE x KSIZE window hold the neighbourhood. A two-stage
// pipeline (weighted products, then sum and shift) produces one filtered
// pixel per push.
// After the last input pixel the block pushes H*COLS+H zero pixels by
// itself. This drains the window, so every frame yields exactly ROWS*COLS
// outputs.
// Optional feature macro GAUSS_BORDER_REPLICATE_EN: out-of-frame taps take
// the nearest in-frame pixel instead of zero.
module gauss_stream_filter #(
  parameter int PIX_W = 8,
  parameter int COLS  = 220,
  parameter int ROWS  = 168,
  parameter int KSIZE = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [PIX_W-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy
);

  localparam int H       = KSIZE / 2;
  localparam int FLUSH_N = H * COLS + H;
  localparam int ACC_W   = PIX_W + 2 * (KSIZE - 1);
  localparam int CW      = $clog2(COLS);
  localparam int RW      = $clog2(ROWS);
  localparam int FW      = $clog2(FLUSH_N + 1);
  localparam int KW      = $clog2(KSIZE);

  if (!(KSIZE == 3 || KSIZE == 5 || KSIZE == 7)) begin : g_bad_ksize
    $error("gauss_stream_filter: KSIZE must be 3, 5 or 7");
  end

  // Binomial coefficient. It is only ever called with constant arguments,
  // so the kernel weights fold to constants.
  function automatic int binom(input int n, input int k);
    int r;
    r = 1;
    for (int t = 0; t < k; t++) begin
      r = r * (n - t) / (t + 1);
    end
    return r;
  endfunction

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    in_col;
  logic [RW-1:0]    in_row;
  logic [CW-1:0]    ocol;
  logic [RW-1:0]    orow;
  logic [FW-1:0]    flush_cnt;

  logic             advance;
  logic             accept;
  logic             flush_push;
  logic             push;
  logic             produce;
  logic             at_center;
  logic             last_in;
  logic             last_taken;
  logic [PIX_W-1:0] push_pix;

  logic [PIX_W-1:0] lb   [KSIZE-1][COLS];
  logic [PIX_W-1:0] colv [KSIZE];
  logic [PIX_W-1:0] win  [KSIZE][KSIZE];
  logic [PIX_W-1:0] nwin [KSIZE][KSIZE];
  logic [ACC_W-1:0] prod     [KSIZE][KSIZE];
  logic [ACC_W-1:0] prod_nxt [KSIZE][KSIZE];
  logic [ACC_W-1:0] sum;
  logic             s1_valid;
  logic             s1_last;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Frame sequencing.
  // FILL ends when the push that centres the window on pixel (0,0) is
  // accepted. RUN ends on the last input pixel. FLUSH ends when the
  // downstream block takes the last output.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = FILL;
      FILL:    if (accept && at_center) state_nxt = RUN;
      RUN:     if (last_in) state_nxt = FLUSH;
      FLUSH:   if (last_taken) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake decode.
  // The whole pipeline moves together whenever the output register is
  // free. A push is either an accepted input pixel or an internal zero
  // pixel during FLUSH.
  always_comb begin
    advance    = !out_valid || out_ready;
    in_ready   = !rst && advance && (state != FLUSH);
    busy       = (state != IDLE);
    accept     = in_valid && in_ready;
    flush_push = (state == FLUSH) && advance && (flush_cnt != FW'(FLUSH_N));
    push       = accept || flush_push;
    push_pix   = accept ? in_data : '0;
    at_center  = (in_row == RW'(H)) && (in_col == CW'(H));
    last_in    = accept && (in_row == RW'(ROWS - 1)) && (in_col == CW'(COLS - 1));
    last_taken = out_valid && out_ready && out_last;
    produce    = push && ((state == RUN) || (state == FLUSH) ||
                          ((state == FILL) && at_center));
  end

  // Push position and output position counters.
  // The output counters name the pixel whose window is being formed by the
  // current push, so the border masks can be derived from them directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_col    <= '0;
      in_row    <= '0;
      ocol      <= '0;
      orow      <= '0;
      flush_cnt <= '0;
    end else begin
      if (push) begin
        if (in_col == CW'(COLS - 1)) begin
          in_col <= '0;
          in_row <= (in_row == RW'(ROWS - 1)) ? '0 : in_row + 1'b1;
        end else begin
          in_col <= in_col + 1'b1;
        end
      end
      if (flush_push) flush_cnt <= flush_cnt + 1'b1;
      if (produce) begin
        if (ocol == CW'(COLS - 1)) begin
          ocol <= '0;
          orow <= (orow == RW'(ROWS - 1)) ? '0 : orow + 1'b1;
        end else begin
          ocol <= ocol + 1'b1;
        end
      end
      if ((state == FLUSH) && last_taken) begin
        in_col    <= '0;
        in_row    <= '0;
        flush_cnt <= '0;
      end
    end
  end

  // Column vector for the current push (index 0 is the newest row) and the
  // window as it will look once the push lands. Column 0 of the window is
  // the newest column.
  always_comb begin
    colv[0] = push_pix;
    for (int k = 1; k < KSIZE; k++) colv[k] = lb[k-1][in_col];
    for (int a = 0; a < KSIZE; a++) begin
      nwin[a][0] = colv[a];
      for (int b = 1; b < KSIZE; b++) nwin[a][b] = win[a][b-1];
    end
  end

  // Line buffers shift one row deeper at the pushed column. The window
  // takes the new column. Stale contents from an earlier frame are harmless
  // because the border logic never selects an out-of-frame tap.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int k = 0; k < KSIZE - 1; k++) lb[k][in_col] <= colv[k];
      win <= nwin;
    end
  end

  // Border handling and weighting.
  // Kernel tap (i,j) of output (orow,ocol) sits at window position
  // (KSIZE-1-i, KSIZE-1-j). Any position whose frame coordinates fall
  // outside the frame may hold wrapped or stale data. Such taps are either
  // zeroed or redirected to the clamped in-frame position.
  always_comb begin
    int               rr;
    int               cc;
    logic [PIX_W-1:0] tap;
    for (int i = 0; i < KSIZE; i++) begin
      for (int j = 0; j < KSIZE; j++) begin
        rr = int'(orow) + i - H;
        cc = int'(ocol) + j - H;
`ifdef GAUSS_BORDER_REPLICATE_EN
        if (rr < 0)         rr = 0;
        else if (rr > ROWS - 1) rr = ROWS - 1;
        if (cc < 0)         cc = 0;
        else if (cc > COLS - 1) cc = COLS - 1;
        tap = nwin[KW'(KSIZE - 1 - (rr - int'(orow) + H))]
                  [KW'(KSIZE - 1 - (cc - int'(ocol) + H))];
`else
        tap = (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS) ?
              nwin[KW'(KSIZE - 1 - i)][KW'(KSIZE - 1 - j)] : '0;
`endif
        prod_nxt[i][j] = ACC_W'(tap) * ACC_W'(binom(KSIZE - 1, i) * binom(KSIZE - 1, j));
      end
    end
  end

  // Product register (first pipeline stage).
  always_ff @(posedge clk) begin
    if (advance) prod <= prod_nxt;
  end

  // Adder tree over all products. The weights sum to 4^(KSIZE-1), so the
  // top PIX_W bits are the normalised result and can never overflow.
  always_comb begin
    sum = '0;
    for (int i = 0; i < KSIZE; i++) begin
      for (int j = 0; j < KSIZE; j++) sum = sum + prod[i][j];
    end
  end

  // Stage valid/last tracking and the output register.
  // Everything holds while the downstream block stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (advance) begin
      s1_valid  <= produce;
      s1_last   <= produce && (orow == RW'(ROWS - 1)) && (ocol == CW'(COLS - 1));
      out_valid <= s1_valid;
      out_last  <= s1_valid && s1_last;
      if (s1_valid) out_data <= sum[ACC_W-1 -: PIX_W];
    end
  end

endmodule

// File: doc/gauss_stream_filter.md
# gauss_stream_filter

Synthesizable streaming successor to the behavioural grayscale Gaussian blur. It accepts one raster-ordered frame of `ROWS`×`COLS` pixels over a valid/ready stream and applies a `KSIZE`×`KSIZE` binomial kernel using on-chip line buffers. It emits the filtered frame in raster order with the same size, and handles backpressure and an end-of-frame flush. It sits between the pixel source (hex loader or DMA) and the image writer in the grayscale path.

## Interface
- `PIX_W`, 8, pixel bit width.
- `COLS`, 220, pixels per row (≥ `KSIZE`).
- `ROWS`, 168, rows per frame (≥ `KSIZE`).
- `KSIZE`, 5, kernel side. Legal values are 3, 5 and 7; any other value is an elaboration error.
- `clk` in 1: the single clock; everything is posedge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: input pixel valid.
- `in_data` in `PIX_W`: input pixel, raster order.
- `in_ready` out 1: the block accepts `in_data` this cycle.
- `out_valid` out 1: output pixel valid.
- `out_data` out `PIX_W`: filtered pixel.
- `out_last` out 1: high with the final pixel of the frame.
- `out_ready` in 1: the downstream block accepts `out_data`.
- `busy` out 1: a frame is in progress (from the first accepted pixel until `out_last` is accepted).

## Operation
- **Kernel.** `w[i][j] = C(K-1,i)·C(K-1,j)`, with weights summing to `4^(K-1)`.
  - Result = `(Σ w·p) >> 2(K-1)`, truncated toward zero.
  - Accumulator width is `PIX_W + 2(K-1)`; the result never exceeds `2^PIX_W - 1`, so no saturation is needed.
- **Border.** Taps that fall outside the frame contribute 0. There is no renormalization, so edge pixels darken.
- **Storage.** `K-1` line buffers of `COLS`×`PIX_W` each, plus a `K`×`K` window register array.
- **Counters.** The input row/column counters and output row/column counters wrap at `COLS`/`ROWS`.
- **FSM states.**
  - `IDLE`: `in_ready=1`. The first accept moves to `FILL`.
  - `FILL`: accept pixels until input index `H·COLS+H` (`H=K/2`) is accepted, then move to `RUN`. Nothing is output in this state.
  - `RUN`: each accept pushes one pixel and produces one output. After the last input pixel (`ROWS·COLS-1`) is accepted, move to `FLUSH`.
  - `FLUSH`: `in_ready=0`. The block internally pushes `H·COLS+H` zero pixels, one per unstalled cycle, and each push produces one output. When `out_last` is accepted, return to `IDLE`.
- **Output count.** Exactly `ROWS·COLS` outputs per frame. `out_last` is asserted only on output (`ROWS-1`, `COLS-1`).
- **Stall rule.** The pipeline advances when `!out_valid || out_ready`.
  - `in_ready = advance && state≠FLUSH`.
  - While stalled, `out_data` and `out_last` hold stable.
- **Back-to-back frames.** The pixel following `out_last` acceptance in `IDLE` starts a new frame. Line-buffer contents are don't-care, because the column and row masks zero every out-of-frame tap.

## Timing
- **Reset values.** `in_ready=0`, `out_valid=0`, `out_data=0`, `out_last=0`, `busy=0`. `state=IDLE`. All counters are 0.
  - `in_ready` rises in the first cycle after `rst` deasserts.
- **Reset mid-frame.** The frame is abandoned, with no further outputs. The next accepted pixel is pixel (0,0).
- **Latency.** Output (r,c) is valid 2 cycles after the cycle in which input (or flush push) index `(r+H)·COLS+(c+H)` is accepted, provided there are no stalls. The pipeline has one register stage for the multiply and one for the sum/shift.
- **Throughput.** 1 pixel per cycle with `in_valid=out_ready=1`. A frame completes in `ROWS·COLS + H·COLS+H + 2` cycles.
- **Simultaneous events.** An input accept and an output handshake in the same cycle are normal. `rst` overrides everything.

## Configuration
- **`GAUSS_BORDER_REPLICATE_EN`** selects the border mode.
  - Defined: out-of-frame taps take the nearest in-frame pixel (clamped row/column), so a constant image filters to the same constant everywhere.
  - Undefined: zero border, as specified above.
- Latency and handshake behaviour are identical in both modes.

## Test plan
All scenarios use `PIX_W=8`, `KSIZE=5`, `ROWS=COLS=8` unless stated.
- **Constant 100 image, zero border.** Interior (2..5, 2..5) = 100, corner (0,0) = 47, edge (0,4) = 68, (1,1) = 87. Exactly 64 outputs; `out_last` appears on the 64th.
- **Constant 100 with `GAUSS_BORDER_REPLICATE_EN`.** All 64 outputs = 100.
- **Impulse 255 at (3,3), zeros elsewhere.** (3,3) = 35, (3,4) = 23, (2,2) = 15, (1,1) = 0, (3,6) = 0.
- **Random image with `out_ready` toggled by a random 50% pattern and `in_valid` gapped.** Outputs match the golden C model bit-exactly, with no drops or duplicates. The bench also checks that `out_data` holds stable while stalled.
- **Reset mid-frame.** Assert `rst` at input pixel 30 for 1 cycle. All outputs go to 0 and `busy=0` on the next cycle; a fresh frame then filters correctly.
- **Back-to-back frames.** Two different frames with `KSIZE=3` and `KSIZE=7` builds, no idle gap between them. Both frames match the model, and there is no bleed from frame 1 into frame 2.
